// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a little-endian UART byte stream into 32-bit
// words, writes them to instruction memory, then hands the memory port to the core.
module instr_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned TIMEOUT   = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        reload,
   output logic [31:0] ins_addr_nap,
   output logic [31:0] ins_data_nap,
   output logic        we_cpu,
   output logic        sel,
   output logic        busy,
   output logic        err,
   output logic [15:0] words_loaded
);

   // TIMEOUT must be at least 2; err becomes visible during the TIMEOUT-th idle cycle,
   // so the trip fires on the edge that closes idle cycle TIMEOUT-1 (count TIMEOUT-2).
   localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDLE_W-1:0] IDLE_TRIP = IDLE_W'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      S_HDR,
      S_DATA,
      S_LAST,
      S_RUN,
      S_ERR
   } state_t;

   state_t            state;
   logic [1:0]        byte_cnt;
   logic [23:0]       asm_p0;
   logic [31:0]       n_words;
   logic [15:0]       word_idx;
   logic [IDLE_W-1:0] idle_cnt;

   logic              accept;
   logic              word_done;
   logic              last_word;
   logic              idle_trip;
   logic [31:0]       word_p0;

   function automatic logic [31:0] word_addr(input logic [15:0] idx);
      return BASE_ADDR + {14'd0, idx, 2'b00};
   endfunction

   always_comb begin
      accept    = rx_valid && !reload && (state == S_HDR || state == S_DATA);
      word_p0   = {rx_data, asm_p0};
      word_done = accept && (byte_cnt == 2'd3);
      last_word = ({16'd0, word_idx} == n_words - 32'd1);
      idle_trip = busy && !accept && (idle_cnt == IDLE_TRIP);
   end

   // ---- p0 byte assembly -> p1 registered write port / FSM ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_HDR;
         byte_cnt     <= '0;
         word_idx     <= '0;
         idle_cnt     <= '0;
         ins_addr_nap <= BASE_ADDR;
         ins_data_nap <= '0;
         we_cpu       <= 1'b0;
         sel          <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         we_cpu <= 1'b0;
         if (reload) begin
            state        <= S_HDR;
            byte_cnt     <= '0;
            word_idx     <= '0;
            idle_cnt     <= '0;
            words_loaded <= '0;
            sel          <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
         end else begin
            if (accept) begin
               asm_p0   <= word_p0[31:8];
               byte_cnt <= byte_cnt + 2'd1;
               idle_cnt <= '0;
            end else if (busy) begin
               idle_cnt <= idle_cnt + 1'b1;
            end

            unique case (state)
               S_HDR: begin
                  if (word_done) begin
                     n_words <= word_p0;
                     if (word_p0 == '0) begin
                        state <= S_RUN;
                        sel   <= 1'b1;
                        busy  <= 1'b0;
                     end else if (word_p0 > MAX_WORDS) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        state    <= S_DATA;
                        word_idx <= '0;
                        busy     <= 1'b1;
                     end
                  end else if (accept) begin
                     busy <= 1'b1;
                  end else if (idle_trip) begin
                     state <= S_ERR;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
               S_DATA: begin
                  if (word_done) begin
                     we_cpu       <= 1'b1;
                     ins_addr_nap <= word_addr(word_idx);
                     ins_data_nap <= word_p0;
                     words_loaded <= words_loaded + 16'd1;
                     word_idx     <= word_idx + 16'd1;
                     if (last_word) begin
                        state <= S_LAST;
                     end
                  end else if (idle_trip) begin
                     // any partially assembled word is simply abandoned
                     state <= S_ERR;
                     err   <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
               S_LAST: begin
                  state <= S_RUN;
                  sel   <= 1'b1;
                  busy  <= 1'b0;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: frames are built from random words and the
// expected memory image is derived directly from the frame contents.
module tb_instr_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          MAXW = 8;
   localparam int          TMO  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        reload;
   logic [31:0] ins_addr_nap;
   logic [31:0] ins_data_nap;
   logic        we_cpu;
   logic        sel;
   logic        busy;
   logic        err;
   logic [15:0] words_loaded;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   logic [31:0] exp_data[$];

   instr_loader #(
      .BASE_ADDR(BASE),
      .MAX_WORDS(MAXW),
      .TIMEOUT  (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .reload      (reload),
      .ins_addr_nap(ins_addr_nap),
      .ins_data_nap(ins_data_nap),
      .we_cpu      (we_cpu),
      .sel         (sel),
      .busy        (busy),
      .err         (err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // write monitor: every write is recorded, never overlaps handover, counter tracks it
   always @(negedge clk) begin
      if (we_cpu === 1'b1) begin
         obs_addr.push_back(ins_addr_nap);
         obs_data.push_back(ins_data_nap);
         check("we_while_sel", {31'd0, sel}, 32'd0);
         check("wl_step", {16'd0, words_loaded}, 32'(obs_addr.size()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
   endtask

   task automatic do_reload();
      reload = 1'b1;
      tick();
      reload = 1'b0;
      clear_obs();
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int b = 0; b < 4; b++) begin
         repeat ($urandom_range(max_gap)) tick();
         put_byte(w[8*b +: 8]);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"}, ins_addr_nap, BASE);
      check({tag, "_data"}, ins_data_nap, 32'd0);
      check({tag, "_we"},   {31'd0, we_cpu}, 32'd0);
      check({tag, "_sel"},  {31'd0, sel}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_err"},  {31'd0, err}, 32'd0);
      check({tag, "_wl"},   {16'd0, words_loaded}, 32'd0);
   endtask

   task automatic verify_writes(input string tag);
      int n;
      n = (obs_addr.size() < exp_data.size()) ? obs_addr.size() : exp_data.size();
      check({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_data.size()));
      for (int i = 0; i < n; i++) begin
         check({tag, "_maddr"}, obs_addr[i], BASE + 32'(4 * i));
         check({tag, "_mdata"}, obs_data[i], exp_data[i]);
      end
   endtask

   // sends header + exp_data, checks write latency and handover timing
   task automatic frame(input int max_gap, input string tag);
      int          n;
      logic [31:0] w;
      n = exp_data.size();
      send_word(32'(n), max_gap);
      for (int i = 0; i < n; i++) begin
         w = exp_data[i];
         send_word(w, max_gap);
         check({tag, "_we"},   {31'd0, we_cpu}, 32'd1);
         check({tag, "_addr"}, ins_addr_nap, BASE + 32'(4 * i));
         check({tag, "_data"}, ins_data_nap, w);
      end
      if (n == 0) begin
         check({tag, "_sel0"},  {31'd0, sel}, 32'd1);
         check({tag, "_busy0"}, {31'd0, busy}, 32'd0);
      end else begin
         check({tag, "_sel_t1"}, {31'd0, sel}, 32'd0);
         tick();
         check({tag, "_sel_t2"},  {31'd0, sel}, 32'd1);
         check({tag, "_we_t2"},   {31'd0, we_cpu}, 32'd0);
         check({tag, "_wl"},      {16'd0, words_loaded}, 32'(n));
         check({tag, "_busy_t2"}, {31'd0, busy}, 32'd0);
      end
      verify_writes(tag);
   endtask

   initial begin
      rst      = 1'b1;
      reload   = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      // directed N=2, back-to-back bytes
      exp_data = '{32'hDEADBEEF, 32'h12345678};
      frame(0, "n2");

      // bytes in RUN are ignored
      put_byte(8'h55);
      tick();
      check("run_ignore", 32'(obs_addr.size()), 32'd2);

      // N == 0
      do_reload();
      check("reload_sel", {31'd0, sel}, 32'd0);
      check("reload_wl", {16'd0, words_loaded}, 32'd0);
      exp_data.delete();
      frame(0, "n0");

      // header too large, then recovery
      do_reload();
      send_word(32'(MAXW + 1), 0);
      check("hdr_err", {31'd0, err}, 32'd1);
      check("hdr_err_sel", {31'd0, sel}, 32'd0);
      send_word(32'hA5A5A5A5, 1);
      repeat (3) tick();
      check("err_hold", {31'd0, err}, 32'd1);
      check("err_nowrite", 32'(obs_addr.size()), 32'd0);
      do_reload();
      check("err_clr", {31'd0, err}, 32'd0);
      exp_data = '{$urandom()};
      frame(1, "recover");

      // timeout with a partial word
      do_reload();
      send_word(32'd1, 0);
      put_byte(8'h11);
      put_byte(8'h22);
      for (int k = 1; k < TMO; k++) begin
         check("tmo_early", {31'd0, err}, 32'd0);
         tick();
      end
      check("tmo_err", {31'd0, err}, 32'd1);
      check("tmo_busy", {31'd0, busy}, 32'd0);
      repeat (4) tick();
      check("tmo_nowrite", 32'(obs_addr.size()), 32'd0);
      check("tmo_sel", {31'd0, sel}, 32'd0);

      // reload wins over a same-cycle byte
      do_reload();
      put_byte(8'h01);
      put_byte(8'h00);
      reload   = 1'b1;
      rx_data  = 8'h07;
      rx_valid = 1'b1;
      tick();
      reload   = 1'b0;
      rx_valid = 1'b0;
      clear_obs();
      check("rl_busy", {31'd0, busy}, 32'd0);
      exp_data = '{$urandom(), $urandom()};
      frame(0, "rl_drop");

      // randomized frames
      for (int r = 0; r < 8; r++) begin
         do_reload();
         exp_data.delete();
         for (int i = 0; i < int'($urandom_range(MAXW, 1)); i++) exp_data.push_back($urandom());
         frame(3, "rand");
      end

      // reset in the middle of DATA after word 0
      do_reload();
      send_word(32'd3, 0);
      send_word(32'hCAFEF00D, 0);
      check("mid_we", {31'd0, we_cpu}, 32'd1);
      put_byte(8'hAA);
      rst      = 1'b1;
      reload   = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h33;
      tick();
      rst      = 1'b0;
      reload   = 1'b0;
      rx_valid = 1'b0;
      check_reset_vals("mid_rst");
      clear_obs();
      tick();
      exp_data = '{$urandom(), $urandom()};
      frame(2, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
